// File: rtl/request_encoder.sv
// request_encoder: collects request strobes from N lines into a sticky pending
// register and hands them out one binary index at a time over a valid/ready
// handshake.
//
// Build option: define REQUEST_ENCODER_RR_EN to replace fixed lowest-index
// priority with a round-robin search that starts just above the last accepted
// index. Without the macro no pointer register exists.
module request_encoder #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         clr_i,
    output logic [W-1:0] code_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] pending_o,
    output logic         overflow_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE_HOT_ZERO = {{(N-1){1'b0}}, 1'b1};

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] code_nxt;
    logic         accept;
    logic [N-1:0] acc_mask;
    logic [N-1:0] pending_nxt;
    logic         dup_hit;
    logic         overflow_nxt;
    logic [W-1:0] sel_code;

    // Lowest set bit wins; x = 0 gives 0, but that result is never used.
    function automatic logic [W-1:0] select_fixed(input logic [N-1:0] x);
        logic [W-1:0] res;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (x[i]) res = W'(i);
        end
        return res;
    endfunction

    // First set bit at or above start, wrapping from N-1 back to 0. The W-bit
    // index arithmetic wraps modulo N because N is a power of two.
    function automatic logic [W-1:0] select_rr(input logic [N-1:0] x,
                                               input logic [W-1:0] start);
        logic [W-1:0] res;
        logic [W-1:0] idx;
        logic         found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = start + W'(i);
            if (!found && x[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // The presented index is accepted when both sides agree at the edge; the
    // accepted line is cleared unless a new strobe on it arrives at once.
    assign valid_o      = (state == PRESENT);
    assign accept       = valid_o & ready_i;
    assign acc_mask     = accept ? (ONE_HOT_ZERO << code_o) : '0;
    assign pending_nxt  = clr_i ? '0 : ((pending_o & ~acc_mask) | req_i);
    assign dup_hit      = |(req_i & pending_o & ~acc_mask);
    assign overflow_nxt = clr_i ? 1'b0 : (overflow_o | dup_hit);

`ifdef REQUEST_ENCODER_RR_EN
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_nxt;

    // The search for the next code already uses the pointer advanced by this
    // cycle's accept, so held requests alternate instead of repeating.
    assign ptr_nxt  = clr_i ? '0 : (accept ? code_o + W'(1) : ptr);
    assign sel_code = select_rr(pending_nxt, ptr_nxt);

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else     ptr <= ptr_nxt;
    end
`else
    assign sel_code = select_fixed(pending_nxt);
`endif

    // Next-state and next-code decode for the handshake FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nxt = state;
        code_nxt  = code_o;
        if (clr_i) begin
            // Flush wins over everything; the last code stays visible.
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pending_nxt != '0) begin
                        code_nxt  = sel_code;
                        state_nxt = PRESENT;
                    end
                end
                PRESENT: begin
                    // Hold the code until it is taken, even if a
                    // higher-priority line shows up meanwhile.
                    if (accept) begin
                        if (pending_nxt != '0) code_nxt  = sel_code;
                        else                   state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Registered state: FSM, presented code, pending lines and overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state      <= IDLE;
            code_o     <= '0;
            pending_o  <= '0;
            overflow_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            code_o     <= code_nxt;
            pending_o  <= pending_nxt;
            overflow_o <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_request_encoder.sv
// Directed bench for request_encoder with a scoreboard: the stimulus pushes
// each code it expects to be accepted, and a monitor pops and compares on
// every cycle where valid_o and ready_i are both high.
module tb_request_encoder;

    localparam int N = 16;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_i = '0;
    logic         clr_i = 1'b0;
    logic         ready_i = 1'b0;
    logic [W-1:0] code_o;
    logic         valid_o;
    logic [N-1:0] pending_o;
    logic         overflow_o;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    request_encoder #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .clr_i      (clr_i),
        .code_o     (code_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .pending_o  (pending_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted code must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected code: got %0d, expected none at %0t", code_o, $time);
            end else begin
                check("scoreboard code", int'(code_o), exp_q.pop_front());
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #1;
        check("reset valid", int'(valid_o), 0);
        check("reset pending", int'(pending_o), 0);
        step();
        rst = 1'b0;

        // Single-line request.
        req_i = 16'h0001; ready_i = 1'b1;
        exp_q.push_back(0);
        step();
        req_i = '0;
        check("single valid", int'(valid_o), 1);
        check("single code", int'(code_o), 0);
        check("single pending", int'(pending_o), 16'h0001);
        step();
        check("single done valid", int'(valid_o), 0);
        check("single done pending", int'(pending_o), 0);

        // Multi-hot pulse with backpressure.
        ready_i = 1'b0; req_i = 16'h8420;
        exp_q.push_back(5); exp_q.push_back(10); exp_q.push_back(15);
        step();
        req_i = '0;
        for (int i = 0; i < 3; i++) begin
            check("backpressure valid", int'(valid_o), 1);
            check("backpressure hold code", int'(code_o), 5);
            step();
        end
        ready_i = 1'b1;
        step(); step(); step();
        check("multi done valid", int'(valid_o), 0);
        check("multi done pending", int'(pending_o), 0);

        // Overflow on a duplicate strobe of line 3.
        ready_i = 1'b0; req_i = 16'h0008;
        exp_q.push_back(3);
        step();
        req_i = '0;
        check("overflow before dup", int'(overflow_o), 0);
        check("overflow code", int'(code_o), 3);
        step();
        req_i = 16'h0008;
        step();
        req_i = '0;
        check("overflow set", int'(overflow_o), 1);
        check("overflow pending", int'(pending_o), 16'h0008);
        ready_i = 1'b1;
        step();
        check("overflow drained valid", int'(valid_o), 0);
        check("overflow sticky", int'(overflow_o), 1);
        step();
        check("overflow still sticky", int'(overflow_o), 1);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        check("overflow cleared", int'(overflow_o), 0);

        // Flush with a same-cycle request that must be discarded.
        ready_i = 1'b0; req_i = 16'h00F0;
        step();
        req_i = 16'h00F0;
        step();
        req_i = '0;
        check("flush pre pending", int'(pending_o), 16'h00F0);
        check("flush pre code", int'(code_o), 4);
        check("flush pre overflow", int'(overflow_o), 1);
        clr_i = 1'b1; req_i = 16'h0001;
        step();
        clr_i = 1'b0; req_i = '0;
        check("flush pending", int'(pending_o), 0);
        check("flush valid", int'(valid_o), 0);
        check("flush overflow", int'(overflow_o), 0);
        check("flush code kept", int'(code_o), 4);
        ready_i = 1'b1;
        step(); step();
        check("flush no code", int'(valid_o), 0);

        // Asynchronous reset in the middle of a handshake.
        ready_i = 1'b0; req_i = 16'h00F0;
        step();
        req_i = 16'h00F0;
        step();
        req_i = '0;
        check("rst pre valid", int'(valid_o), 1);
        check("rst pre overflow", int'(overflow_o), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst pending", int'(pending_o), 0);
        check("async rst valid", int'(valid_o), 0);
        check("async rst code", int'(code_o), 0);
        check("async rst overflow", int'(overflow_o), 0);
        step();
        rst = 1'b0;

        // Priority mode with two lines held high.
`ifdef REQUEST_ENCODER_RR_EN
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
        exp_q.push_back(1); exp_q.push_back(0);
`else
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(0); exp_q.push_back(1);
`endif
        ready_i = 1'b1; req_i = 16'h0003;
        step(); step(); step(); step();
        req_i = '0;
        check("priority overflow", int'(overflow_o), 1);
        step(); step();
        check("priority done valid", int'(valid_o), 0);
        check("priority done pending", int'(pending_o), 0);

        step();
        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/request_encoder.md
Name: request_encoder

Overview:
- Sequential counterpart to the one-hot decoders in the IAS machine datapath.
- Collects one-hot or multi-hot request pulses from N lines into a sticky pending register.
- Encodes the pending lines into binary indices, one index at a time, and hands each index to a consumer over a valid/ready handshake.
- Used to turn control/interrupt-style line strobes back into a 4-bit selector for the control unit.

Parameters:
- N, 16, number of request lines.
- W, 4, width of the encoded index; must equal log2(N). N must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req_i  input  N  request strobes, sampled every rising edge; any number of bits may be high.
- clr_i  input  1  synchronous flush of all pending state.
- code_o  output  W  binary index of the presented request.
- valid_o  output  1  code_o is valid.
- ready_i  input  1  consumer accepts code_o when valid_o and ready_i are both high at a rising edge.
- pending_o  output  N  current pending register.
- overflow_o  output  1  sticky flag: a request arrived on a line that was already pending.

Behaviour:
- Reset (async, rst=1):
  - pending_o = 0, code_o = 0, valid_o = 0, overflow_o = 0.
  - State = IDLE; round-robin pointer = 0.
  - Effective immediately, including mid-handshake; pending requests are lost.
- accept = valid_o & ready_i.
- acc_mask = one-hot(code_o) if accept, else 0.
- pending_nxt = clr_i ? 0 : ((pending_o & ~acc_mask) | req_i).
  - A new request on the line being accepted in the same cycle re-sets that bit (set wins over clear).
- select(x): index of the lowest set bit of x (fixed priority); undefined when x = 0, and never used then.
- States:
  - IDLE (valid_o = 0):
    - If clr_i=0 and pending_nxt != 0: code_o <= select(pending_nxt), valid_o <= 1, go to PRESENT.
    - Otherwise stay in IDLE.
  - PRESENT (valid_o = 1):
    - code_o is held stable while ready_i = 0, even if higher-priority requests arrive.
    - On accept with pending_nxt != 0: code_o <= select(pending_nxt) and stay in PRESENT. Back-to-back throughput is 1 code per cycle.
    - On accept with pending_nxt = 0: valid_o <= 0, go to IDLE.
- Latency: a request sampled at edge t (with the block idle) gives valid_o = 1 and the correct code_o right after edge t.
- clr_i: highest priority after rst.
  - At the edge: pending <= 0, valid_o <= 0, overflow_o <= 0, state <= IDLE.
  - req_i in the same cycle is discarded.
  - code_o keeps its last value.
- overflow_o:
  - Set at the edge when any k has req_i[k] & pending_o[k] & ~acc_mask[k].
  - Cleared only by clr_i or rst.
  - The duplicate request is merged: only one code is delivered.
- pending_o: register output, updated each edge to pending_nxt.
- Wrap-around: none in fixed-priority mode. Index arithmetic is modulo N.

Optional Feature:
- Macro: REQUEST_ENCODER_RR_EN.
- Defined:
  - select(x) searches upward from pointer ptr, wrapping from N-1 to 0.
  - On each accept, ptr <= (code_o + 1) mod N; index 15 wraps ptr to 0.
  - ptr resets to 0 on rst and clr_i.
- Not defined:
  - Fixed lowest-index priority; no ptr register is synthesized.
- Handshake, latency and flags are identical in both modes.

Test Plan:
- Reset mid-handshake: pending = 0x00F0, valid_o = 1, then rst pulse between edges -> pending_o, valid_o, code_o and overflow_o are 0 immediately (asynchronously).
- Single-line request: req_i = 0x0001 for one cycle, ready_i = 1 -> after that edge valid_o = 1, code_o = 0, pending_o = 0x0001; next edge accepts -> valid_o = 0, pending_o = 0.
- Multi-hot pulse with backpressure: one cycle of req_i = 0x8420, ready_i = 0 for 3 cycles -> code_o = 5 held stable. Then ready_i = 1 -> codes 5, 10, 15 on consecutive cycles, then valid_o = 0 and pending_o = 0.
- Overflow: req_i bit 3 pulsed twice while ready_i = 0 -> overflow_o = 1. Then ready_i = 1 -> exactly one code 3 is delivered, and overflow_o stays 1 until clr_i.
- Flush: pending = 0x00F0 and valid_o = 1, then clr_i = 1 with req_i = 0x0001 in the same cycle -> next cycle pending_o = 0, valid_o = 0, overflow_o = 0, and no code 0 is ever presented.
- Priority mode: req_i = 0x0003 held high, ready_i = 1 ->
  - without the macro: code_o = 0 every cycle, overflow_o = 1;
  - with REQUEST_ENCODER_RR_EN: code_o alternates 0, 1, 0, 1.
